pri_enc_serializer: RTL

Parametrised, sequential successor to the team's 4-to-2 encoder. It accepts an N-bit request vector through a valid/ready handshake and emits the binary index of every set bit, one per handshake, on a valid/ready output. Selection order is fixed-priority (lowest index first) or round-robin, chosen by parameter. It sits between event/flag sources and any consumer that needs encoded indices rather than one-hot or multi-hot vectors.

---
 rtl/pri_enc_pkg.sv | 13 +
 rtl/pri_pick.sv | 38 +++
 rtl/pri_enc_serializer.sv | 93 +++++++++
 3 files changed

// File: rtl/pri_enc_pkg.sv
// Shared types and constants for the priority-encoder serializer.
// Holds the FSM state encoding and the selection-mode constants.
package pri_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/pri_pick.sv
// Combinational picker: first set bit at or above ptr, else lowest set bit.
// Also reports whether any bit is set and whether exactly one bit is set.
module pri_pick
  import pri_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         single
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask[gi] = (gi >= int'(ptr));
  end

  assign masked = vec & mask;
  // Nothing at or above ptr means the search wraps to the unmasked vector.
  assign src    = (|masked) ? masked : vec;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) idx = W'(i);
    end
  end

  assign found  = |vec;
  assign single = found && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/pri_enc_serializer.sv
// Accepts a multi-hot request vector and emits the index of each set bit,
// one per output handshake, in fixed-priority or round-robin order.
module pri_enc_serializer
  import pri_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = 0,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_pulse,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         zero_q, zero_d;

  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic         pick_single;

  pri_pick #(.N(N)) u_pick (
    .vec    (pending_q),
    .ptr    (ptr_q),
    .idx    (pick_idx),
    .found  (pick_found),
    .single (pick_single)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    zero_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_vec == '0) begin
            zero_d = 1'b1;
          end else begin
            pending_d = in_vec;
            state_d   = SCAN;
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pending_d = pending_q & ~(N'(1) << pick_idx);
          // Wrap at N so a non-power-of-two width never points past N-1.
          if (MODE == MODE_RR) begin
            ptr_d = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
          end
          if (pick_single || !pick_found) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      zero_q    <= zero_d;
    end
  end

  assign out_idx    = pick_idx;
  assign out_last   = pick_single;
  assign zero_pulse = zero_q;
  assign busy       = (state_q == SCAN);

endmodule
